// File: rtl/shift_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier, one multiplier bit per clock.
// 16-bit a times N-bit b, product on a 32-bit bus with a one-cycle strobe.
module shift_multiplier #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  a,
    input  logic [N-1:0] b,
    input  logic         vld,
    output logic [31:0]  c,
    output logic         result_vld
);

    localparam int W  = 16 + N;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   mcand;
    logic [W-1:0]   acc;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           last;

    assign last = (cnt == CW'(N - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (vld) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // mcand walks left and mplier walks right, so bit i adds mcand << i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand      <= '0;
            mplier     <= '0;
            acc        <= '0;
            cnt        <= '0;
            c          <= '0;
            result_vld <= 1'b0;
        end else begin
            result_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (vld) begin
                        mcand  <= W'(a);
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                DONE: begin
                    c          <= 32'(acc);
                    result_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_multiplier.sv
// Self-checking bench for shift_multiplier: vector table, random ops
// against a plain a*b model, plus reset/abort/back-to-back sequences.
module tb_shift_multiplier;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [15:0]  a;
    logic [N-1:0] b;
    logic         vld;
    logic [31:0]  c;
    logic         result_vld;

    int errors = 0;
    int checks = 0;

    shift_multiplier #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .vld        (vld),
        .c          (c),
        .result_vld (result_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  a;
        logic [N-1:0] b;
        logic [31:0]  exp;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] x,
                                          input logic [N-1:0] y);
        longint unsigned p;
        p = longint'(x) * longint'(y);
        return p[31:0];
    endfunction

    // waits for result_vld; returns edge count after E0 (0 = timeout)
    task automatic wait_result(input int limit, output int k);
        k = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (result_vld) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic do_op(input string nm, input logic [15:0] x,
                         input logic [N-1:0] y, input logic [31:0] exp);
        int k;
        @(negedge clk);
        a   = x;
        b   = y;
        vld = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        vld = 1'b0;
        a   = 16'($urandom);
        b   = N'($urandom);
        wait_result(N + 6, k);
        chk({nm, "_latency"}, k, N + 1);
        chk({nm, "_c"}, c, exp);
        @(posedge clk);
        #1;
        chk({nm, "_strobe_len"}, {31'd0, result_vld}, 0);
    endtask

    initial begin
        int k;
        int seen;
        logic [31:0] hold;
        logic [N-1:0] bb;
        logic [15:0] aa;

        tbl[0] = '{a: 16'd4,     b: 4'd5,  exp: 32'd20};
        tbl[1] = '{a: 16'd65535, b: 4'd9,  exp: 32'd589815};
        tbl[2] = '{a: 16'hFFFF,  b: 4'hF,  exp: 32'd983025};
        tbl[3] = '{a: 16'd0,     b: 4'hF,  exp: 32'd0};
        tbl[4] = '{a: 16'd1234,  b: 4'd0,  exp: 32'd0};
        tbl[5] = '{a: 16'd1,     b: 4'd1,  exp: 32'd1};
        tbl[6] = '{a: 16'd300,   b: 4'd8,  exp: 32'd2400};

        // reset held with vld high: nothing starts, outputs stay zero
        rst_n = 1'b0;
        vld   = 1'b1;
        a     = 16'd5;
        b     = 4'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("reset_c", c, 0);
            chk("reset_vld", {31'd0, result_vld}, 0);
        end
        @(negedge clk);
        vld   = 1'b0;
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk);
            #1;
            if (result_vld) seen++;
        end
        chk("idle_after_reset", seen, 0);

        for (int i = 0; i < 7; i++)
            do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp);
        chk("full_scale_upper_zero", {20'd0, c[31:20]}, 0);

        // output holds between products
        hold = c;
        repeat (5) @(posedge clk);
        #1;
        chk("c_hold", c, hold);

        // sparse multipliers (popcount <= 2) with assorted multiplicands
        for (int v = 0; v < (1 << N); v++) begin
            bb = N'(v);
            if ($countones(bb) <= 2) begin
                aa = 16'($urandom);
                do_op($sformatf("sweep_b%0d", v), aa, bb, model(aa, bb));
            end
        end

        for (int i = 0; i < 30; i++) begin
            aa = 16'($urandom);
            bb = N'($urandom);
            do_op($sformatf("rand%0d", i), aa, bb, model(aa, bb));
        end

        // abort mid-operation with reset
        @(negedge clk);
        a   = 16'd7;
        b   = 4'd3;
        vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_c", c, 0);
        chk("abort_vld", {31'd0, result_vld}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk);
            #1;
            if (result_vld) seen++;
        end
        chk("abort_no_result", seen, 0);
        do_op("after_abort", 16'd7, 4'd3, 32'd21);

        // operands change while busy; vld held for a back-to-back op
        @(negedge clk);
        a   = 16'd10;
        b   = 4'd2;
        vld = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        a = 16'd99;
        b = 4'd15;
        wait_result(N + 6, k);
        chk("busy_change_latency", k, N + 1);
        chk("busy_change_c", c, 32'd20);
        wait_result(N + 6, k);
        chk("b2b_latency", k, N + 2);
        chk("b2b_c", c, 32'd1485);
        @(negedge clk);
        vld = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
